// File: rtl/qif_neuron_scheduler.sv
// rtl/qif_neuron_scheduler.sv - time-multiplexed scheduler sharing one QIF neuron datapath
// Sweeps all virtual neurons per tick: one req/ack datapath update each, refractory neurons skipped.
module qif_neuron_scheduler #(
  parameter int                N_NEURONS    = 4,
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] V_RESET      = '0,
  parameter int                REFRAC_STEPS = 2,
  parameter int                TIMEOUT      = 15,
  localparam int               ADDR_W       = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 dp_req,
  input  logic                 dp_ack,
  output logic [DATA_W-1:0]    dp_v_in,
  output logic [DATA_W-1:0]    dp_i_syn,
  input  logic [DATA_W-1:0]    dp_v_out,
  input  logic                 dp_spike,
  output logic                 busy,
  output logic                 step_done,
  output logic [N_NEURONS-1:0] spike_vec,
  input  logic                 clr_flags,
  output logic                 overrun,
  output logic                 timeout
);

  localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W:0] N_LIM = (ADDR_W + 1)'(N_NEURONS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_SKIP, S_WB, S_DONE} state_t;

  state_t               state;
  logic [DATA_W-1:0]    v_mem  [N_NEURONS];
  logic [DATA_W-1:0]    i_syn  [N_NEURONS];
  logic [RW-1:0]        refrac [N_NEURONS];
  logic [ADDR_W-1:0]    idx;
  logic [CW-1:0]        wait_cnt;
  logic [DATA_W-1:0]    res_v;
  logic                 res_spike;
  logic                 res_valid;
  logic [N_NEURONS-1:0] spike_acc;
  logic [N_NEURONS-1:0] acc_next;
  logic                 last_idx;
  logic                 wr_ok;
  logic                 rd_ok;

  assign last_idx = (idx == ADDR_W'(N_NEURONS - 1));
  assign wr_ok    = ({1'b0, wr_addr} < N_LIM);
  assign rd_ok    = ({1'b0, rd_addr} < N_LIM);

  // res_valid is low after an abandoned handshake, so WB leaves the neuron untouched
  always_comb begin
    acc_next = spike_acc;
    if (state == S_WB && res_valid && res_spike) acc_next[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      res_v     <= '0;
      res_spike <= 1'b0;
      res_valid <= 1'b0;
      spike_acc <= '0;
      dp_req    <= 1'b0;
      dp_v_in   <= '0;
      dp_i_syn  <= '0;
      busy      <= 1'b0;
      step_done <= 1'b0;
      spike_vec <= '0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
      rd_data   <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem[k]  <= V_RESET;
        i_syn[k]  <= '0;
        refrac[k] <= '0;
      end
    end else begin
      step_done <= 1'b0;
      rd_data   <= rd_ok ? v_mem[rd_addr] : '0;
      if (wr_en && wr_ok) i_syn[wr_addr] <= wr_data;
      // a new event in the same cycle as clr_flags keeps the flag set
      overrun   <= (overrun && !clr_flags) || (tick && state != S_IDLE);
      timeout   <= timeout && !clr_flags;

      case (state)
        S_IDLE: begin
          if (tick) begin
            state     <= S_LOAD;
            idx       <= '0;
            busy      <= 1'b1;
            spike_acc <= '0;
          end
        end
        S_LOAD: begin
          if (refrac[idx] != '0) begin
            state <= S_SKIP;
          end else begin
            dp_v_in  <= v_mem[idx];
            dp_i_syn <= i_syn[idx];
            dp_req   <= 1'b1;
            wait_cnt <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (dp_ack) begin
            res_v     <= dp_v_out;
            res_spike <= dp_spike;
            res_valid <= 1'b1;
            dp_req    <= 1'b0;
            state     <= S_WB;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            timeout   <= 1'b1;
            res_valid <= 1'b0;
            dp_req    <= 1'b0;
            state     <= S_WB;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_SKIP, S_WB: begin
          if (state == S_SKIP) begin
            refrac[idx] <= refrac[idx] - RW'(1);
            v_mem[idx]  <= V_RESET;
          end else if (res_valid) begin
            if (res_spike) begin
              v_mem[idx]  <= V_RESET;
              refrac[idx] <= RW'(REFRAC_STEPS);
            end else begin
              v_mem[idx] <= res_v;
            end
          end
          spike_acc <= acc_next;
          if (last_idx) begin
            spike_vec <= acc_next;
            step_done <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx   <= idx + ADDR_W'(1);
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          spike_acc <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
